// File: rtl/spi_xfer_fsm.sv
// SPI master transfer engine.
// Pops words from the TX FIFO, generates SCLK from a half-period divider, shifts MSB-first on
// MOSI while capturing MISO, and pushes each received word to the RX FIFO. The cs_pull_low /
// cs_pull_high pulses drive chip-select auto mode in the downstream select block.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_enable            block enable; 0 aborts any transfer and holds IDLE
//   i_tx_valid          TX FIFO not empty
//   i_tx_data           TX FIFO head word, right-justified
//   o_tx_pop            pulse: i_tx_data consumed
//   i_word_size         bits per word minus 1
//   i_brd               SCLK half-period minus 1, in clk cycles (read live)
//   i_cpol, i_cpha      SPI mode
//   i_miso              serial data in (already synchronised)
//   o_sclk, o_mosi      serial clock / data out
//   o_rx_data           received word, right-justified, upper bits 0
//   o_rx_push           pulse: o_rx_data valid
//   o_cs_pull_low       pulse: transfer starting
//   o_cs_pull_high      pulse: last bit finished
//   o_busy              transfer in progress
module spi_xfer_fsm #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BRD_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_tx_valid,
  input  logic [DATA_W-1:0] i_tx_data,
  output logic              o_tx_pop,
  input  logic [4:0]        i_word_size,
  input  logic [BRD_W-1:0]  i_brd,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_push,
  output logic              o_cs_pull_low,
  output logic              o_cs_pull_high,
  output logic              o_busy
);

  typedef enum logic [1:0] {StIdle, StCsAssert, StTxRx} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [BRD_W-1:0]    r_hp;
  logic [DATA_W-1:0]   r_txw;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic [4:0]          r_bcount;
  // Remaining SCLK edges minus 1; odd value means the next edge is a leading one.
  logic [5:0]          r_edges;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_sclk;
  logic                r_mosi;
  // Keeps the engine from popping in the very first cycle after reset release.
  logic                r_armed;

  logic                w_tick;
  logic                w_lead;
  logic                w_start;
  logic                w_last;
  logic                w_sample;
  logic [DATA_W-1:0]   w_rx_next;
  logic [DATA_W-1:0]   w_word;

  // >= keeps the divider from running away if brd is lowered mid-count.
  assign w_tick    = (r_hp >= i_brd);
  assign w_lead    = r_edges[0];
  assign w_start   = (r_state == StIdle) && r_armed && i_enable && i_tx_valid;
  assign w_last    = (r_state == StTxRx) && w_tick && (r_edges == 6'd0) && i_enable;
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign w_sample  = (r_state == StTxRx) && w_tick && (w_lead ^ r_cpha);
  assign w_rx_next = {r_rx[DATA_W-2:0], i_miso};
  // With cpha=1 the final sample lands in the same cycle as the push.
  assign w_word    = r_cpha ? w_rx_next : r_rx;

  assign o_tx_pop       = w_start;
  assign o_cs_pull_low  = w_start;
  assign o_rx_push      = w_last;
  assign o_cs_pull_high = w_last;
  assign o_busy         = (r_state != StIdle);
  assign o_rx_data      = w_last ? w_word : r_rx_data;
  assign o_sclk         = r_sclk;
  assign o_mosi         = r_mosi;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (!i_enable) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:     if (w_start) w_state_d = StCsAssert;
        StCsAssert: if (w_tick) w_state_d = StTxRx;
        StTxRx:     if (w_tick && (r_edges == 6'd0)) w_state_d = StIdle;
        default:    w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hp      <= '0;
      r_txw     <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_bcount  <= '0;
      r_edges   <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_armed <= 1'b1;

      if ((w_state_d != r_state) || (r_state == StIdle) || w_tick) begin
        r_hp <= '0;
      end else begin
        r_hp <= r_hp + BRD_W'(1);
      end

      if (!i_enable) begin
        r_sclk <= i_cpol;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_sclk <= i_cpol;
            if (w_start) begin
              r_txw    <= i_tx_data;
              r_bcount <= i_word_size;
              r_edges  <= {i_word_size, 1'b1};
              r_cpol   <= i_cpol;
              r_cpha   <= i_cpha;
              r_rx     <= '0;
              r_mosi   <= i_tx_data[i_word_size];
            end
          end
          StCsAssert: begin
          end
          StTxRx: begin
            if (w_tick) begin
              r_edges <= r_edges - 6'd1;
              r_sclk  <= w_lead ? ~r_cpol : r_cpol;
              // Drive the next bit on the edge opposite to sampling.
              if (w_lead == r_cpha) begin
                r_mosi <= r_txw[r_bcount];
              end
            end
            if (w_sample) begin
              r_rx <= w_rx_next;
              if (r_bcount != 5'd0) r_bcount <= r_bcount - 5'd1;
            end
            if (w_last) begin
              r_rx_data <= w_word;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_xfer_fsm.sv
module tb_spi_xfer_fsm;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_pop;
  logic [4:0]  word_size;
  logic [15:0] brd;
  logic        cpol;
  logic        cpha;
  logic        miso;
  logic        sclk;
  logic        mosi;
  logic [31:0] rx_data;
  logic        rx_push;
  logic        cs_low;
  logic        cs_high;
  logic        busy;

  logic        loop_en;
  logic        miso_val;

  int n_total = 0;
  int n_bad   = 0;

  assign miso = loop_en ? mosi : miso_val;

  spi_xfer_fsm #(.DATA_W(32), .BRD_W(16)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_tx_valid     (tx_valid),
    .i_tx_data      (tx_data),
    .o_tx_pop       (tx_pop),
    .i_word_size    (word_size),
    .i_brd          (brd),
    .i_cpol         (cpol),
    .i_cpha         (cpha),
    .i_miso         (miso),
    .o_sclk         (sclk),
    .o_mosi         (mosi),
    .o_rx_data      (rx_data),
    .o_rx_push      (rx_push),
    .o_cs_pull_low  (cs_low),
    .o_cs_pull_high (cs_high),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_mask(input int ws);
    logic [63:0] m;
    m = (64'd1 << (ws + 1)) - 64'd1;
    return m[31:0];
  endfunction

  // One word: expected echo, MOSI bit order, pulse count and latency from the mode rules.
  task automatic do_word(input int ws, input int bd, input bit pol, input bit pha,
                         input logic [31:0] data, input bit lp, input bit mv);
    logic [31:0] mask;
    logic [31:0] exp_rx;
    logic [31:0] bits_acc;
    int          nbits;
    int          pulses;
    int          n;
    int          lat;
    int          limit;
    bit          got_pop;
    bit          got_push;
    logic        prev;
    logic [31:0] rx_seen;
    logic        csh_seen;

    mask   = word_mask(ws);
    exp_rx = lp ? (data & mask) : (mv ? mask : 32'd0);
    lat    = (2 * (ws + 1) + 1) * (bd + 1);
    limit  = lat + 20;

    @(posedge clk); #1;
    word_size = 5'(ws);
    brd       = 16'(bd);
    cpol      = pol;
    cpha      = pha;
    loop_en   = lp;
    miso_val  = mv;
    tx_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_data  = data;
    tx_valid = 1'b1;

    got_pop = 1'b0;
    for (int i = 0; i < 8 && !got_pop; i++) begin
      @(negedge clk);
      if (tx_pop) got_pop = 1'b1;
    end
    check_val("pop_seen", 32'(got_pop), 32'd1);
    if (!got_pop) begin
      tx_valid = 1'b0;
      return;
    end
    check_val("cs_low_with_pop", 32'(cs_low), 32'd1);
    check_val("sclk_idle", 32'(sclk), 32'(pol));
    prev = sclk;

    @(posedge clk); #1;
    tx_valid = 1'b0;

    nbits    = 0;
    bits_acc = '0;
    pulses   = 0;
    n        = 0;
    got_push = 1'b0;
    rx_seen  = '0;
    csh_seen = 1'b0;
    // One extra cycle after the push catches the final trailing SCLK edge.
    for (int extra = 0; extra < 1 && n < limit; ) begin
      @(negedge clk);
      n++;
      if (sclk !== prev) begin
        if (sclk !== pol) pulses++;
        if ((sclk !== pol) != pha) begin
          bits_acc = (bits_acc << 1) | 32'(mosi);
          nbits++;
        end
        prev = sclk;
      end
      if (got_push) begin
        extra++;
      end else if (rx_push) begin
        got_push = 1'b1;
        lat      = lat - n;
        rx_seen  = rx_data;
        csh_seen = cs_high;
      end
    end

    check_val("push_seen", 32'(got_push), 32'd1);
    check_val("latency_err", 32'(lat), 32'd0);
    check_val("rx_data", rx_seen, exp_rx);
    check_val("cs_high_with_push", 32'(csh_seen), 32'd1);
    check_val("sclk_pulses", 32'(pulses), 32'(ws + 1));
    check_val("mosi_bits", bits_acc, data & mask);
    check_val("busy_after", 32'(busy), 32'd0);
    check_val("sclk_end", 32'(sclk), 32'(pol));
  endtask

  initial begin
    logic [31:0] rx_list[$];
    int          pops;
    int          pushes;
    int          cyc;
    int          t_high;
    int          t_low2;
    int          rises;
    int          bad_pulses;
    bit          ok;

    rst_n    = 1'b0;
    enable   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    word_size = 5'd7;
    brd      = 16'd1;
    cpol     = 1'b1;
    cpha     = 1'b0;
    loop_en  = 1'b1;
    miso_val = 1'b0;

    #22;
    check_val("rst_sclk", 32'(sclk), 32'd0);
    check_val("rst_mosi", 32'(mosi), 32'd0);
    check_val("rst_rx_data", rx_data, 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_pulses", {28'd0, tx_pop, rx_push, cs_low, cs_high}, 32'd0);

    @(posedge clk); #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check_val("idle_tracks_cpol", 32'(sclk), 32'd1);

    // Directed cases.
    do_word(7, 1, 1'b0, 1'b0, 32'h0000_00A5, 1'b1, 1'b0);
    do_word(15, 0, 1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    do_word(0, 1, 1'b0, 1'b0, 32'h0000_0001, 1'b1, 1'b0);
    do_word(31, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Two words back to back.
    @(posedge clk); #1;
    word_size = 5'd7;
    brd       = 16'd2;
    cpol      = 1'b0;
    cpha      = 1'b0;
    loop_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_data  = 32'h0000_005A;
    tx_valid = 1'b1;
    pops = 0; pushes = 0; cyc = 0; t_high = -100; t_low2 = 0;
    while (pushes < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (rx_push) begin
        pushes++;
        rx_list.push_back(rx_data);
      end
      if (cs_high && pushes == 1) t_high = cyc;
      if (tx_pop) begin
        pops++;
        if (pops == 2) t_low2 = cyc;
      end
      @(posedge clk); #1;
      if (tx_pop && pops == 1) tx_data = 32'h0000_00C3;
      if (pops == 2) tx_valid = 1'b0;
    end
    tx_valid = 1'b0;
    check_val("b2b_pops", 32'(pops), 32'd2);
    check_val("b2b_pushes", 32'(pushes), 32'd2);
    check_val("b2b_rx0", (rx_list.size() > 0) ? rx_list[0] : 32'hFFFF_FFFF, 32'h0000_005A);
    check_val("b2b_rx1", (rx_list.size() > 1) ? rx_list[1] : 32'hFFFF_FFFF, 32'h0000_00C3);
    check_val("b2b_cs_gap", 32'(t_low2 - t_high), 32'd1);

    // Abort by dropping enable while SCLK is in its active phase (mode 2).
    @(posedge clk); #1;
    word_size = 5'd7;
    brd       = 16'd1;
    cpol      = 1'b1;
    cpha      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tx_data  = 32'h0000_003C;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (tx_pop) ok = 1'b1;
    end
    check_val("abort_pop", 32'(ok), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    rises = 0;
    for (int i = 0; i < 100 && rises < 4; i++) begin
      @(negedge clk);
      if (sclk === 1'b0) begin
        rises++;
        if (rises < 4) begin
          while (sclk === 1'b0 && i < 100) begin
            @(negedge clk);
            i++;
          end
        end
      end
    end
    check_val("abort_reached", 32'(rises), 32'd4);
    #1;
    enable = 1'b0;
    bad_pulses = 0;
    @(negedge clk);
    if (rx_push || cs_high) bad_pulses++;
    @(negedge clk);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_sclk", 32'(sclk), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_push || cs_high) bad_pulses++;
    end
    check_val("abort_no_pulses", 32'(bad_pulses), 32'd0);
    #1;
    enable = 1'b1;
    do_word(7, 1, 1'b1, 1'b0, 32'h0000_0096, 1'b1, 1'b0);

    // Reset mid-transfer.
    @(posedge clk); #1;
    word_size = 5'd7;
    brd       = 16'd1;
    cpol      = 1'b0;
    cpha      = 1'b0;
    loop_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_data  = 32'h0000_00FF;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (12) @(negedge clk);
    check_val("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_sclk", 32'(sclk), 32'd0);
    check_val("mid_rst_mosi", 32'(mosi), 32'd0);
    check_val("mid_rst_rx_data", rx_data, 32'd0);
    check_val("mid_rst_pulses", {28'd0, tx_pop, rx_push, cs_low, cs_high}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Randomized words across all modes, sizes and small dividers.
    for (int k = 0; k < 24; k++) begin
      do_word(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
